// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR filter controller. One multiply-accumulate per clock
//   against an external delay-line RAM (samples) and coefficient ROM (Q1.(CW-1)).
//   After reset the delay line is zero-filled. Each accepted sample is written
//   at wr_ptr. NTAPS taps are then read newest-to-oldest and accumulated, and
//   the scaled result is presented with a valid/ready handshake.
//
//   Build option: define FIR_SATURATE_EN to clamp the output to the DW-bit
//   signed range. Left undefined, the output wraps (low DW bits).
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     sample input handshake, in_data (DW, signed)
//   sram_addr/we/wdata    delay-line RAM write/read address and write data
//   sram_rdata            delay-line read data, 1-cycle latency
//   crom_addr/crom_rdata  coefficient ROM address / data, 1-cycle latency
//   out_valid/out_ready   result handshake, out_data (DW, signed)
//   busy                  high whenever the sequencer is not idle
module fir_mac_sequencer #(
    parameter int NTAPS = 62,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int AW    = 6,
    parameter int ACCW  = 38
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [AW-1:0] sram_addr,
    output logic          sram_we,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic [AW-1:0] crom_addr,
    input  logic [CW-1:0] crom_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

`ifdef FIR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [AW-1:0] LAST    = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_W = (AW + 1)'(NTAPS);
    localparam int            PW      = DW + CW;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_WRITE  = 3'd2,
        S_MAC    = 3'd3,
        S_DRAIN  = 3'd4,
        S_OUTPUT = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    // k doubles as the zero-fill address counter during CLEAR
    logic [AW-1:0]           k_q, k_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [DW-1:0]           sample_q, sample_d;
    // a product is on the RAM/ROM data buses this cycle (address issued last cycle)
    logic                    prod_vld_q, prod_vld_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic [AW:0]             rd_addr_w;
    logic signed [ACCW-1:0]  acc_sh;
    logic                    fits;
    logic [DW-1:0]           sat_word;
    logic [DW-1:0]           out_word;

    assign prod     = $signed(sram_rdata) * $signed(crom_rdata);
    assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};

    // (wr_ptr - k) mod NTAPS without a divider: both operands are < NTAPS
    always_comb begin
        if (wr_ptr_q >= k_q)
            rd_addr_w = {1'b0, wr_ptr_q} - {1'b0, k_q};
        else
            rd_addr_w = {1'b0, wr_ptr_q} + NTAPS_W - {1'b0, k_q};
    end

    // Drop the Q1.(CW-1) fraction bits, then either clamp or wrap to DW bits
    assign acc_sh   = acc_q >>> (CW - 1);
    assign fits     = (acc_sh[ACCW-1:DW-1] == {(ACCW - DW + 1){acc_sh[DW-1]}});
    assign sat_word = fits ? acc_sh[DW-1:0]
                    : (acc_sh[ACCW-1] ? {1'b1, {(DW - 1){1'b0}}}
                                      : {1'b0, {(DW - 1){1'b1}}});
    assign out_word = SAT_EN ? sat_word : acc_sh[DW-1:0];

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        k_d        = k_q;
        acc_d      = acc_q;
        sample_d   = sample_q;
        prod_vld_d = (state_q == S_MAC);

        in_ready   = 1'b0;
        sram_addr  = '0;
        sram_we    = 1'b0;
        sram_wdata = '0;
        crom_addr  = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = 1'b1;

        // the product issued in the previous MAC cycle lands here (MAC k>=1 or DRAIN)
        if (prod_vld_q)
            acc_d = acc_q + prod_ext;

        case (state_q)
            S_CLEAR: begin
                sram_we   = 1'b1;
                sram_addr = k_q;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                sram_we    = 1'b1;
                sram_addr  = wr_ptr_q;
                sram_wdata = sample_q;
                acc_d      = '0;
                k_d        = '0;
                state_d    = S_MAC;
            end
            S_MAC: begin
                sram_addr = rd_addr_w[AW-1:0];
                crom_addr = k_q;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                out_data  = out_word;
                if (out_ready) begin
                    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                // unreachable encodings: recover through a full zero-fill
                k_d        = '0;
                acc_d      = '0;
                prod_vld_d = 1'b0;
                state_d    = S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            wr_ptr_q   <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            sample_q   <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            sample_q   <= sample_d;
            prod_vld_q <= prod_vld_d;
        end
    end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter NTAPS, default 62: number of filter taps; SHALL be at least 2.
REQ-002 Parameter DW, default 16: signed sample width.
REQ-003 Parameter CW, default 16: signed coefficient width, Q1.(CW-1).
REQ-004 Parameter AW, default 6: RAM/ROM address width; 2^AW >= NTAPS.
REQ-005 Parameter ACCW, default 38: accumulator width; ACCW >= DW+CW+ceil(log2(NTAPS)).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  input sample offered.
REQ-009 in_ready  out  1  block accepts the sample this cycle.
REQ-010 in_data  in  DW  signed input sample.
REQ-011 sram_addr  out  AW  sample delay-line RAM address.
REQ-012 sram_we  out  1  delay-line RAM write enable.
REQ-013 sram_wdata  out  DW  delay-line RAM write data.
REQ-014 sram_rdata  in  DW  delay-line read data, 1-cycle synchronous latency, read-after-write of the previous cycle returns new data.
REQ-015 crom_addr  out  AW  coefficient ROM address.
REQ-016 crom_rdata  in  CW  coefficient data, 1-cycle synchronous latency.
REQ-017 out_valid  out  1  filtered sample available.
REQ-018 out_ready  in  1  consumer accepts out_data.
REQ-019 out_data  out  DW  signed filtered sample.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 States: CLEAR, IDLE, WRITE, MAC, DRAIN, OUTPUT.
REQ-022 CLEAR: sram_we=1, sram_wdata=0, sram_addr counts 0..NTAPS-1 (one per cycle); after address NTAPS-1, go to IDLE.
REQ-023 IDLE: in_ready=1; on in_valid, capture in_data, go to WRITE; otherwise stay.
REQ-024 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored.
REQ-025 WRITE: sram_we=1, sram_addr=wr_ptr, sram_wdata=captured sample; clear accumulator and tap counter k; go to MAC.
REQ-026 MAC: one tap per cycle, k=0..NTAPS-1: sram_addr=(wr_ptr-k) mod NTAPS, crom_addr=k, sram_we=0.
REQ-027 MAC: product sram_rdata*crom_rdata is signed full-width (DW+CW) and sign-extended into the accumulator one cycle after its address issue.
REQ-028 After issuing k=NTAPS-1, go to DRAIN; DRAIN accumulates the last product, then go to OUTPUT.
REQ-029 OUTPUT: out_valid=1, out_data=(acc >>> (CW-1)) reduced to DW bits per REQ-038; hold out_valid and out_data stable until out_ready.
REQ-030 When out_valid && out_ready: wr_ptr = (wr_ptr==NTAPS-1) ? 0 : wr_ptr+1, go to IDLE; the single-cycle handshake is legal.
REQ-031 Latency: sample accepted at cycle T gives first out_valid at T+NTAPS+3 (65 at default).
REQ-032 crom_addr and sram_addr SHALL be 0 in any state not driving them; sram_wdata SHALL be 0 when sram_we=0.
REQ-033 Invalid state encoding SHALL return to CLEAR.

Reset
REQ-034 Reset asserted: state=CLEAR, wr_ptr=0, k=0, acc=0, out_valid=0, out_data=0, in_ready=0, busy=1, immediately and without waiting for clk.
REQ-035 Reset mid-operation aborts the computation, discards any pending output, and re-runs the full CLEAR sequence after deassertion.
REQ-036 in_ready first goes high NTAPS cycles after the first clk edge following reset deassertion.

Configuration
REQ-037 Macro FIR_SATURATE_EN selects output saturation.
REQ-038 With FIR_SATURATE_EN defined, out_data saturates the shifted accumulator to [-2^(DW-1), 2^(DW-1)-1]; without it, out_data is the low DW bits of the shifted accumulator (wrap).

Verification
REQ-039 Reset, then idle -> sram_we=1 for 62 cycles, addr 0..61, wdata 0, in_ready=0; in_ready=1 on the 63rd cycle.
REQ-040 coef[k]=0x0100*(k+1); input 0x4000 followed by zeros -> outputs 0x0080, 0x0100, 0x0180, ... (0x0080*(n+1)), then 0x0000 after 62 samples.
REQ-041 Sample accepted at cycle T with out_ready=1 -> out_valid high exactly at T+65 for one cycle, in_ready high at T+66.
REQ-042 out_ready held 0 for 10 cycles in OUTPUT -> out_valid, out_data stable, in_ready=0, in_valid pulses ignored.
REQ-043 All coef 0x7FFF, 62 inputs of 0x7FFF -> 62nd output 0x7FFF with FIR_SATURATE_EN, 0xFF84 without.
REQ-044 Reset pulsed during MAC -> out_valid=0 immediately, CLEAR repeats 62 writes, next impulse response matches REQ-040 from a zeroed line.
